// File: rtl/fpu_sched_if.sv
// Exec-stage <-> FPU scheduler signal bundle.
// The slave modport is the scheduler side; the master modport is the pipeline/FPU side.
interface fpu_sched_if;
  logic        issue_valid;
  logic [4:0]  fpu_op;
  logic        flush;
  logic        fpu_done;
  logic [31:0] fpu_result;
  logic        fpu_start;
  logic [4:0]  fpu_op_q;
  logic        stall_e;
  logic        result_valid;
  logic [31:0] result_q;
  logic        busy;
  logic        err;

  modport slave (
    input  issue_valid, fpu_op, flush, fpu_done, fpu_result,
    output fpu_start, fpu_op_q, stall_e, result_valid, result_q, busy, err
  );

  modport master (
    output issue_valid, fpu_op, flush, fpu_done, fpu_result,
    input  fpu_start, fpu_op_q, stall_e, result_valid, result_q, busy, err
  );
endinterface

// File: rtl/fpu_sched.sv
// Multi-cycle FPU issue scheduler: launches ops, stalls the pipeline for fixed or
// variable latency, captures the result and handles flush/timeout/abort.
module fpu_sched #(
  parameter int unsigned LAT_ADD = 2,
  parameter int unsigned LAT_MUL = 2,
  parameter int unsigned TIMEOUT = 63
) (
  input logic         clk,
  input logic         rst,
  fpu_sched_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COUNT     = 3'd1,
    WAIT_DONE = 3'd2,
    DONE      = 3'd3,
    ABORT     = 3'd4
  } state_t;

  localparam logic [7:0] LAT_ADD_C = 8'(LAT_ADD);
  localparam logic [7:0] LAT_MUL_C = 8'(LAT_MUL);
  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t      r_state, w_next;
  logic [7:0]  r_cnt, w_cnt_next, w_cnt_inc;
  logic [4:0]  r_op_q;
  logic [31:0] r_result;
  logic        r_err;

  logic [1:0]  w_cls;
  logic        w_accept, w_timeout;
  logic        w_start, w_stall, w_rv;
  logic        w_capture, w_set_err;
  logic [31:0] w_capture_val;

  assign w_cls     = bus.fpu_op[4:3];
  assign w_accept  = (r_state == IDLE) && bus.issue_valid && !bus.flush && (w_cls != 2'b00);
  assign w_timeout = (r_cnt == TIMEOUT_C);
  // Counter saturates instead of wrapping so a stuck unit cannot alias a small count.
  assign w_cnt_inc = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;

  always_comb begin
    w_next        = r_state;
    w_cnt_next    = r_cnt;
    w_start       = 1'b0;
    w_stall       = 1'b0;
    w_rv          = 1'b0;
    w_capture     = 1'b0;
    w_capture_val = bus.fpu_result;
    w_set_err     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_start = 1'b1;
          w_stall = 1'b1;
          if (w_cls == 2'b11) begin
            w_next     = WAIT_DONE;
            w_cnt_next = '0;
          end else begin
            w_next     = COUNT;
            w_cnt_next = (w_cls == 2'b01) ? LAT_ADD_C : LAT_MUL_C;
          end
        end
      end
      COUNT: begin
        if (bus.flush) begin
          w_next = IDLE;
        end else begin
          w_stall    = 1'b1;
          w_cnt_next = (r_cnt != '0) ? r_cnt - 8'd1 : r_cnt;
          if (r_cnt <= 8'd1) begin
            w_capture = 1'b1;
            w_next    = DONE;
          end
        end
      end
      WAIT_DONE: begin
        w_cnt_next = w_cnt_inc;
        if (bus.flush) begin
          w_next = ABORT;
        end else begin
          w_stall = 1'b1;
          // fpu_done takes priority over a coincident timeout.
          if (bus.fpu_done) begin
            w_capture = 1'b1;
            w_next    = DONE;
          end else if (w_timeout) begin
            w_capture     = 1'b1;
            w_capture_val = '0;
            w_set_err     = 1'b1;
            w_next        = DONE;
          end
        end
      end
      DONE: begin
        w_rv   = !bus.flush;
        w_next = IDLE;
      end
      ABORT: begin
        w_cnt_next = w_cnt_inc;
        w_stall    = bus.issue_valid && (w_cls != 2'b00);
        if (bus.fpu_done || w_timeout) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_op_q   <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_start)   r_op_q   <= bus.fpu_op;
      if (w_capture) r_result <= w_capture_val;
      if (w_set_err) r_err    <= 1'b1;
    end
  end

  assign bus.fpu_start    = w_start && !rst;
  assign bus.stall_e      = w_stall && !rst;
  assign bus.result_valid = w_rv && !rst;
  assign bus.fpu_op_q     = r_op_q;
  assign bus.result_q     = r_result;
  assign bus.busy         = (r_state != IDLE);
  assign bus.err          = r_err;

endmodule

// File: tb/tb_fpu_sched.sv
// Directed self-checking bench for fpu_sched (LAT_ADD=2, LAT_MUL=3, TIMEOUT=63).
module tb_fpu_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  fpu_sched_if bus ();

  fpu_sched #(.LAT_ADD(2), .LAT_MUL(3), .TIMEOUT(63)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [4:0] op, input logic [31:0] res);
    bus.issue_valid = 1'b1;
    bus.fpu_op      = op;
    bus.fpu_result  = res;
  endtask

  initial begin
    bus.issue_valid = 1'b1;
    bus.fpu_op      = 5'b01000;
    bus.flush       = 1'b0;
    bus.fpu_done    = 1'b0;
    bus.fpu_result  = 32'h0;

    // Reset: outputs forced low while rst is high, state cleared after.
    #1;
    chk1("rst_start", bus.fpu_start, 1'b0);
    chk1("rst_stall", bus.stall_e, 1'b0);
    chk1("rst_rv", bus.result_valid, 1'b0);
    tick; tick;
    rst = 1'b0; bus.issue_valid = 1'b0;
    #1;
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_err", bus.err, 1'b0);
    chk32("rst_res", bus.result_q, 32'h0);
    chk32("rst_opq", {27'h0, bus.fpu_op_q}, 32'h0);

    // fadd, LAT_ADD=2: stall t..t+2, result_valid at t+3.
    tick; issue(5'b01000, 32'h3F800000); #1;
    chk1("add_start", bus.fpu_start, 1'b1);
    chk1("add_stall_t", bus.stall_e, 1'b1);
    tick; bus.issue_valid = 1'b0; #1;
    chk1("add_start_t1", bus.fpu_start, 1'b0);
    chk1("add_stall_t1", bus.stall_e, 1'b1);
    chk32("add_opq", {27'h0, bus.fpu_op_q}, 32'h08);
    tick; #1;
    chk1("add_stall_t2", bus.stall_e, 1'b1);
    chk1("add_rv_t2", bus.result_valid, 1'b0);
    tick; #1;
    chk1("add_stall_t3", bus.stall_e, 1'b0);
    chk1("add_rv_t3", bus.result_valid, 1'b1);
    chk32("add_res", bus.result_q, 32'h3F800000);
    tick; #1;
    chk1("add_rv_t4", bus.result_valid, 1'b0);
    chk1("add_busy_t4", bus.busy, 1'b0);

    // fmul, LAT_MUL=3: stall t..t+3, result_valid at t+4.
    tick; issue(5'b10000, 32'h40000000); #1;
    chk1("mul_start", bus.fpu_start, 1'b1);
    tick; bus.issue_valid = 1'b0; #1;
    tick; #1;
    tick; #1;
    chk1("mul_stall_t3", bus.stall_e, 1'b1);
    chk1("mul_rv_t3", bus.result_valid, 1'b0);
    tick; #1;
    chk1("mul_rv_t4", bus.result_valid, 1'b1);
    chk32("mul_res", bus.result_q, 32'h40000000);

    // fadd flushed in DONE: no result_valid, back to IDLE.
    tick; issue(5'b01001, 32'h11111111); #1;
    tick; bus.issue_valid = 1'b0; #1;
    tick; #1;
    tick; bus.flush = 1'b1; #1;
    chk1("dflush_rv", bus.result_valid, 1'b0);
    chk1("dflush_busy", bus.busy, 1'b1);
    tick; bus.flush = 1'b0; #1;
    chk1("dflush_idle", bus.busy, 1'b0);

    // No accept: class 00, and a flushed issue; fpu_done in IDLE ignored.
    tick; issue(5'b00101, 32'h0); #1;
    chk1("c00_start", bus.fpu_start, 1'b0);
    chk1("c00_stall", bus.stall_e, 1'b0);
    tick; bus.fpu_op = 5'b01000; bus.flush = 1'b1; #1;
    chk1("iflush_start", bus.fpu_start, 1'b0);
    chk1("c00_busy", bus.busy, 1'b0);
    tick; bus.issue_valid = 1'b0; bus.flush = 1'b0; bus.fpu_done = 1'b1; #1;
    tick; bus.fpu_done = 1'b0; #1;
    chk1("idone_busy", bus.busy, 1'b0);
    chk1("idone_rv", bus.result_valid, 1'b0);

    // fdiv: done at t+15 -> stall through t+15, result at t+16.
    tick; issue(5'b11000, 32'h40490FDB); #1;
    chk1("div_start", bus.fpu_start, 1'b1);
    tick; bus.issue_valid = 1'b0; #1;
    repeat (13) tick;
    tick; bus.fpu_done = 1'b1; #1;
    chk1("div_stall_done", bus.stall_e, 1'b1);
    chk1("div_rv_done", bus.result_valid, 1'b0);
    tick; bus.fpu_done = 1'b0; #1;
    chk1("div_rv", bus.result_valid, 1'b1);
    chk1("div_stall_rv", bus.stall_e, 1'b0);
    chk32("div_res", bus.result_q, 32'h40490FDB);
    chk1("div_err", bus.err, 1'b0);

    // fsqrt: done arrives exactly at counter==TIMEOUT -> done wins, no err.
    tick; issue(5'b11001, 32'h12345678); #1;
    tick; bus.issue_valid = 1'b0; #1;
    repeat (62) tick;
    tick; bus.fpu_done = 1'b1; #1;
    chk1("tie_stall", bus.stall_e, 1'b1);
    tick; bus.fpu_done = 1'b0; #1;
    chk1("tie_rv", bus.result_valid, 1'b1);
    chk32("tie_res", bus.result_q, 32'h12345678);
    chk1("tie_err", bus.err, 1'b0);

    // fmul flushed at t+1: stall low at t+1, IDLE at t+2, no result.
    tick; issue(5'b10000, 32'h22222222); #1;
    chk1("mflush_start", bus.fpu_start, 1'b1);
    tick; bus.issue_valid = 1'b0; bus.flush = 1'b1; #1;
    chk1("mflush_stall", bus.stall_e, 1'b0);
    tick; bus.flush = 1'b0; #1;
    chk1("mflush_idle", bus.busy, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk1("mflush_rv", bus.result_valid, 1'b0);
      tick;
    end

    // fdiv flushed -> ABORT; fadd held stalled, accepted after IDLE, one result.
    tick; issue(5'b11000, 32'h33333333); #1;
    tick; bus.issue_valid = 1'b0; bus.flush = 1'b1; #1;
    chk1("ab_flush_stall", bus.stall_e, 1'b0);
    tick; bus.flush = 1'b0; issue(5'b01000, 32'h44444444); #1;
    chk1("ab_busy", bus.busy, 1'b1);
    chk1("ab_stall", bus.stall_e, 1'b1);
    chk1("ab_nostart", bus.fpu_start, 1'b0);
    tick; bus.fpu_done = 1'b1; #1;
    chk1("ab_stall2", bus.stall_e, 1'b1);
    tick; bus.fpu_done = 1'b0; #1;
    chk1("ab_accept", bus.fpu_start, 1'b1);
    chk1("ab_rv_none", bus.result_valid, 1'b0);
    tick; bus.issue_valid = 1'b0; #1;
    chk1("ab_rv_t1", bus.result_valid, 1'b0);
    tick; #1;
    tick; #1;
    chk1("ab_rv_add", bus.result_valid, 1'b1);
    chk32("ab_res", bus.result_q, 32'h44444444);

    // fsqrt timeout: result_q zeroed, err set and sticky.
    tick; issue(5'b11001, 32'hDEADBEEF); #1;
    tick; bus.issue_valid = 1'b0; #1;
    repeat (62) tick;
    tick; #1;
    chk1("to_stall", bus.stall_e, 1'b1);
    chk1("to_rv_early", bus.result_valid, 1'b0);
    tick; #1;
    chk1("to_rv", bus.result_valid, 1'b1);
    chk32("to_res", bus.result_q, 32'h0);
    chk1("to_err", bus.err, 1'b1);
    repeat (3) tick;
    chk1("to_err_sticky", bus.err, 1'b1);
    chk1("to_idle", bus.busy, 1'b0);

    // rst mid-COUNT, then a late fpu_done: everything cleared, no result.
    tick; issue(5'b01000, 32'h55555555); #1;
    tick; bus.issue_valid = 1'b0; rst = 1'b1; #1;
    chk1("mr_stall", bus.stall_e, 1'b0);
    chk1("mr_rv", bus.result_valid, 1'b0);
    tick; rst = 1'b0; #1;
    chk1("mr_busy", bus.busy, 1'b0);
    chk1("mr_err", bus.err, 1'b0);
    chk32("mr_res", bus.result_q, 32'h0);
    chk32("mr_opq", {27'h0, bus.fpu_op_q}, 32'h0);
    tick; bus.fpu_done = 1'b1; #1;
    tick; bus.fpu_done = 1'b0; #1;
    for (int i = 0; i < 4; i++) begin
      chk1("mr_late_rv", bus.result_valid, 1'b0);
      tick;
    end
    chk1("mr_late_busy", bus.busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fpu_sched.md
FPU_SCHED -- requirements
Module: fpu_sched

Interface
REQ-001 Parameter LAT_ADD, default 2: cycles from fpu_start to valid fpu_result for class 01 (fadd/fsub); legal range 1..15.
REQ-002 Parameter LAT_MUL, default 2: same for class 10 (fmul); legal range 1..15.
REQ-003 Parameter TIMEOUT, default 63: maximum cycles waited for fpu_done on class 11 (fdiv/fsqrt); legal range 1..255.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 issue_valid  in  1  exec stage holds an FPU instruction this cycle.
REQ-007 fpu_op  in  5  operation code; fpu_op[4:3] is the class: 00 single-cycle, 01 add, 10 mul, 11 variable-latency.
REQ-008 flush  in  1  hazard-unit kill of the instruction in exec.
REQ-009 fpu_done  in  1  FPU unit completion pulse for class 11.
REQ-010 fpu_result  in  32  FPU unit result bus.
REQ-011 fpu_start  out  1  one-cycle launch pulse to the FPU unit.
REQ-012 fpu_op_q  out  5  operation code latched at launch, held until the next launch.
REQ-013 stall_e  out  1  freeze fetch/decode/exec pipeline registers.
REQ-014 result_valid  out  1  result_q is valid for write-back this cycle.
REQ-015 result_q  out  32  captured FPU result.
REQ-016 busy  out  1  FSM is not in IDLE.
REQ-017 err  out  1  sticky timeout flag.

Function
REQ-018 The FSM has exactly the states IDLE, COUNT, WAIT_DONE, DONE and ABORT.
REQ-019 Accept condition: state IDLE, issue_valid=1, flush=0, class != 00.
REQ-020 On accept (cycle t): fpu_start=1 and stall_e=1 combinationally in cycle t; fpu_op_q <= fpu_op.
REQ-021 On accept, the block loads the counter with LAT_ADD or LAT_MUL for class 01 or 10 and enters COUNT; for class 11 it clears the counter and enters WAIT_DONE.
REQ-022 COUNT: stall_e=1; the counter decrements each cycle; at counter==1, result_q <= fpu_result and next state is DONE.
REQ-023 A fixed-latency op accepted at t has stall_e=1 in cycles t..t+LAT and result_valid=1 in cycle t+LAT+1 only.
REQ-024 WAIT_DONE: stall_e=1; the counter increments each cycle; on fpu_done=1, result_q <= fpu_result and next state is DONE.
REQ-025 WAIT_DONE timeout: on counter==TIMEOUT with fpu_done=0, result_q <= 32'h0, err <= 1 and next state is DONE.
REQ-026 DONE: stall_e=0 and result_valid=1 for exactly one cycle; issue_valid is ignored; next state is IDLE.
REQ-027 Class 00, or issue_valid=0, or flush=1 while in IDLE: no accept; fpu_start=0, stall_e=0, no state change.
REQ-028 flush=1 in COUNT: next state is IDLE; result_valid is never asserted for that op; stall_e=0 in the flush cycle.
REQ-029 flush=1 in WAIT_DONE: next state is ABORT; stall_e=0 from the flush cycle onward.
REQ-030 ABORT: stall_e=0 and busy=1; fpu_done or timeout returns to IDLE without result_valid.
REQ-031 In ABORT, an incoming multi-cycle op (issue_valid=1, class != 00) forces stall_e=1 and is not accepted until IDLE.
REQ-032 flush=1 in DONE: result_valid is forced to 0; next state is IDLE.
REQ-033 fpu_done outside WAIT_DONE/ABORT is ignored.
REQ-034 fpu_done and timeout in the same cycle: fpu_done wins and err is not set.
REQ-035 Back-to-back ops: the earliest second accept is the cycle after DONE, i.e. t+LAT+2.
REQ-036 The counter is 8 bits wide and does not wrap.
REQ-037 err clears only on rst.

Reset
REQ-038 When rst=1 at a clock edge, the state becomes IDLE.
REQ-039 At that edge, the counter, fpu_op_q, result_q and err are all cleared to 0.
REQ-040 While rst=1, fpu_start=0, stall_e=0 and result_valid=0, overriding any operation in progress.
REQ-041 An in-flight class-11 op interrupted by rst is abandoned; a subsequent fpu_done is ignored.

Verification
REQ-042 fadd (fpu_op=5'b01000), LAT_ADD=2, issue at t=10 with fpu_result=32'h3F800000 -> fpu_start at 10; stall_e at 10..12; result_valid at 13 with result_q=32'h3F800000.
REQ-043 fdiv (5'b11000) issued at t=5, fpu_done at t=20 with result 32'h40490FDB -> stall_e at 5..20; result_valid at 21; err=0.
REQ-044 fsqrt issued, fpu_done never arrives, TIMEOUT=63 -> result_valid one cycle after counter reaches 63; result_q=0; err=1 until rst.
REQ-045 fmul issued at t, flush at t+1 -> stall_e=0 at t+1, IDLE at t+2, result_valid never asserted.
REQ-046 fdiv issued, flush, then fadd presented while in ABORT -> stall_e held; fadd accepted the cycle after IDLE is reached; exactly one result_valid, for the fadd.
REQ-047 rst asserted mid-COUNT, then a late fpu_done -> all outputs 0 in the cycle after reset, and no result_valid is produced.
